// File: rtl/des_pkg.sv
// DES constant tables, FSM state type and the bit-permutation helpers shared by
// the iterative core and its round stage. All tables use DES 1-based MSB-first
// bit numbers; a [N:1] vector holds DES bit n at index N+1-n.
package des_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam int unsigned IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int unsigned E [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int unsigned P [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Row s holds S(s+1); entry index is {row, col} = {b1, b6, b2..b5}.
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [64:1] ip(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65 - i] = x[65 - IP[i - 1]];
        return y;
    endfunction

    function automatic logic [64:1] fp(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65 - i] = x[65 - FP[i - 1]];
        return y;
    endfunction

    // Returns {C0, D0}; parity bits (8, 16, ...) are never selected.
    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] y;
        for (int i = 1; i <= 56; i++) y[57 - i] = k[65 - PC1[i - 1]];
        return y;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] y;
        for (int i = 1; i <= 48; i++) y[49 - i] = cd[57 - PC2[i - 1]];
        return y;
    endfunction

    // Key rotation amount for global round j (1..16).
    function automatic int unsigned shift_of(input logic [4:0] j);
        int unsigned s = 1;
        for (int i = 1; i <= 16; i++) if (j == 5'(i)) s = SHIFT[i - 1];
        return s;
    endfunction

    function automatic logic [28:1] rotl28(input logic [28:1] x, input int unsigned n);
        return (n == 1) ? {x[27:1], x[28]} : {x[26:1], x[28:27]};
    endfunction

    function automatic logic [28:1] rotr28(input logic [28:1] x, input int unsigned n);
        return (n == 1) ? {x[1], x[28:2]} : {x[2:1], x[28:3]};
    endfunction

    // f(R, K) = P(S(E(R) xor K))
    function automatic logic [32:1] feistel(input logic [32:1] r, input logic [48:1] k);
        logic [48:1] x;
        logic [5:0]  b;
        logic [32:1] s;
        logic [32:1] y;
        int unsigned v;
        for (int i = 1; i <= 48; i++) x[49 - i] = r[33 - E[i - 1]];
        x = x ^ k;
        for (int n = 0; n < 8; n++) begin
            b = x[48 - 6 * n -: 6];
            v = SBOX[n][int'({b[5], b[0], b[4:1]})];
            s[32 - 4 * n -: 4] = v[3:0];
        end
        for (int i = 1; i <= 32; i++) y[33 - i] = s[33 - P[i - 1]];
        return y;
    endfunction

endpackage

// File: rtl/des_iter_core_round.sv
// One combinational DES round with its key-schedule step.
//   l, r            : round input halves
//   c, d            : key register halves before this round
//   decrypt         : 0 = encrypt (rotate left, then PC2); 1 = decrypt (PC2, then rotate right)
//   j               : global round number 1..16
//   l_next..d_next  : halves after the round
module des_round
    import des_pkg::*;
(
    input  logic [32:1] l,
    input  logic [32:1] r,
    input  logic [28:1] c,
    input  logic [28:1] d,
    input  logic        decrypt,
    input  logic [4:0]  j,
    output logic [32:1] l_next,
    output logic [32:1] r_next,
    output logic [28:1] c_next,
    output logic [28:1] d_next
);

    logic [48:1] k;

    always_comb begin
        k      = '0;
        c_next = c;
        d_next = d;
        if (!decrypt) begin
            c_next = rotl28(c, shift_of(j));
            d_next = rotl28(d, shift_of(j));
            k      = pc2({c_next, d_next});
        end else begin
            // Decrypt walks the schedule backwards: C0 == C16 after PC1.
            k      = pc2({c, d});
            c_next = rotr28(c, shift_of(5'd17 - j));
            d_next = rotr28(d, shift_of(5'd17 - j));
        end
    end

    assign l_next = r;
    assign r_next = l ^ feistel(r, k);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt engine evaluating RPC rounds per clock.
//   clock, reset            : rising-edge clock, async active-high reset
//   in_valid/in_ready       : accept in_data/in_key/in_decrypt (only while idle)
//   out_valid/out_ready     : result handshake; out_data held until accepted
//   busy                    : high while a block is in flight or awaiting output
module des_iter_core
    import des_pkg::*;
#(
    parameter int unsigned RPC = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic [64:1] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        busy
);

    localparam int unsigned NCYC = 16 / RPC;

    if (NCYC * RPC != 16) begin : g_bad_rpc
        $error("des_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:1] l_q, l_d, r_q, r_d;
    logic [28:1] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic [64:1] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    logic [32:1] l_ch [RPC + 1];
    logic [32:1] r_ch [RPC + 1];
    logic [28:1] c_ch [RPC + 1];
    logic [28:1] d_ch [RPC + 1];

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        des_round u_round (
            .l      (l_ch[g]),
            .r      (r_ch[g]),
            .c      (c_ch[g]),
            .d      (d_ch[g]),
            .decrypt(mode_q),
            .j      (cnt_q + 5'(g) + 5'd1),
            .l_next (l_ch[g + 1]),
            .r_next (r_ch[g + 1]),
            .c_next (c_ch[g + 1]),
            .d_next (d_ch[g + 1])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    {l_d, r_d} = ip(in_data);
                    {c_d, d_d} = pc1(in_key);
                    mode_d     = in_decrypt;
                    cnt_d      = '0;
                    state_d    = StRound;
                end
            end
            StRound: begin
                l_d   = l_ch[RPC];
                r_d   = r_ch[RPC];
                c_d   = c_ch[RPC];
                d_d   = d_ch[RPC];
                cnt_d = cnt_q + 5'(RPC);
                if (cnt_q == 5'(16 - RPC)) begin
                    // Halves are swapped before the final permutation.
                    out_data_d  = fp({r_ch[RPC], l_ch[RPC]});
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
